// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: synchronises and debounces 10 active-low keys and emits
// one priority-encoded event per press. Define KEY_REPEAT_EN to enable auto-repeat.
module key_scan_ctrl #(
    parameter int DEB_CYC    = 4,
    parameter int REPEAT_DLY = 16,
    parameter int REPEAT_PER = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] S_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int CNT_W = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESS,
        HOLD,
        DB_REL
    } state_t;

    if (DEB_CYC < 2) begin : g_bad_deb
        $error("key_scan_ctrl: DEB_CYC must be at least 2");
    end
    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_rpt
        $error("key_scan_ctrl: REPEAT_DLY and REPEAT_PER must be at least 1");
    end

    state_t           state;
    state_t           next_state;
    logic [9:0]       s_meta;
    logic [9:0]       s_sync;
    logic             any_key;
    logic [3:0]       key_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cap;
    logic             push;
    logic             accept;
    logic             rpt_fire;

    // Two-flop synchroniser; idle level of the keypad is all-ones.
    // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= '1;
            s_sync <= '1;
        end else begin
            s_meta <= S_n;
            s_sync <= s_meta;
        end
    end

    // Highest-numbered pressed key wins.
    always_comb begin
        any_key = ~&s_sync;
        key_idx = '0;
        for (int i = 0; i < 10; i++) begin
            if (!s_sync[i]) key_idx = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state takes a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_key) next_state = DB_PRESS;
            end
            DB_PRESS: begin
                if (!any_key || key_idx != cap) next_state = IDLE;
                else if (cnt == CNT_MAX)        next_state = PRESS;
            end
            PRESS: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (!any_key) next_state = DB_REL;
            end
            DB_REL: begin
                if (any_key)             next_state = HOLD;
                else if (cnt == CNT_MAX) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Debounce counter runs only in the two debounce states; cap tracks the key while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cap <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    cap <= key_idx;
                end
                DB_PRESS, DB_REL: begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_target;

    assign rpt_target = rpt_first ? RPT_W'(REPEAT_DLY - 1) : RPT_W'(REPEAT_PER - 1);
    assign rpt_fire   = (state == HOLD) && (rpt_cnt == rpt_target);

    // Counts HOLD cycles only: frozen while the release is being debounced,
    // cleared once the key is really gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HOLD) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else if (state != DB_REL) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        key_held = (state == HOLD) || (state == DB_REL);
        push     = (state == PRESS) || rpt_fire;
        accept   = push && (!key_valid || key_ready);
    end

    // Single-entry event register; a push that finds it occupied is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                key_code  <= cap;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            if (push && !accept) ovf <= 1'b1;
            else if (ovf_clr)    ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: table vectors, directed corner sequences
// and randomized key traffic compared against a debounce-window reference model.
module tb_key_scan_ctrl;

    localparam int DEB_CYC    = 4;
    localparam int REPEAT_DLY = 16;
    localparam int REPEAT_PER = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] S_n = 10'h3FF;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_held;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    always #5 clk = ~clk;

    key_scan_ctrl #(
        .DEB_CYC   (DEB_CYC),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .S_n      (S_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a press is a window of DEB_CYC+1 consecutive samples showing the
    // same top key, a release a window of DEB_CYC+1 consecutive empty samples.
    logic [9:0] m_meta, m_sync;
    bit         m_down, m_due, m_first, m_valid, m_ovf;
    int         m_win, m_age;
    logic [3:0] m_wcode, m_code;

    function automatic logic [3:0] top_key(input logic [9:0] v);
        for (int i = 9; i >= 0; i--) begin
            if (v[i] == 1'b0) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_meta  = '1;
        m_sync  = '1;
        m_down  = 0;
        m_due   = 0;
        m_win   = 0;
        m_age   = 0;
        m_first = 1;
        m_wcode = '0;
        m_code  = '0;
        m_valid = 0;
        m_ovf   = 0;
    endtask

    task automatic m_edge(input logic [9:0] s, input logic rdy, input logic clr);
        logic [9:0] v;
        bit         any, push, drop;
        logic [3:0] code;
        v      = m_sync;
        m_sync = m_meta;
        m_meta = s;
        any    = (v != 10'h3FF);
        code   = top_key(v);
        push   = 0;
        if (m_due) begin
            push    = 1;
            m_due   = 0;
            m_down  = 1;
            m_win   = 0;
            m_age   = 0;
            m_first = 1;
        end else if (!m_down) begin
            if (m_win == 0) begin
                if (any) begin
                    m_win   = 1;
                    m_wcode = code;
                end
            end else if (any && code == m_wcode) begin
                m_win++;
                if (m_win == DEB_CYC + 1) m_due = 1;
            end else begin
                m_win = 0;
            end
        end else begin
`ifdef KEY_REPEAT_EN
            if (m_win == 0) begin
                m_age++;
                if (m_age == (m_first ? REPEAT_DLY : REPEAT_PER)) begin
                    push    = 1;
                    m_age   = 0;
                    m_first = 0;
                end
            end
`endif
            if (any) begin
                m_win = 0;
            end else begin
                m_win++;
                if (m_win == DEB_CYC + 1) begin
                    m_down  = 0;
                    m_win   = 0;
                    m_age   = 0;
                    m_first = 1;
                end
            end
        end
        drop = push && m_valid && !rdy;
        if (push && !drop) begin
            m_code  = m_wcode;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass, compares at the next falling edge.
    task automatic step(input logic [9:0] s, input logic rdy, input logic clr);
        S_n       = s;
        key_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        m_edge(s, rdy, clr);
        @(negedge clk);
        check("model", {key_code, key_valid, key_held, ovf}, {m_code, m_valid, m_down, m_ovf});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", {key_code, key_valid, key_held, ovf}, 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [9:0] s_n;
        logic       exp_valid;
        logic [3:0] exp_code;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n_ev, exp_n, rel_n;
        int         ev_q[$];
        logic [3:0] seen_code;
        logic [9:0] pat;

        tbl[0] = '{"key5",      10'h3DF, 1'b1, 4'd5};
        tbl[1] = '{"keys2_7",   10'h37B, 1'b1, 4'd7};
        tbl[2] = '{"key0",      10'h3FE, 1'b1, 4'd0};
        tbl[3] = '{"none",      10'h3FF, 1'b0, 4'd0};
        tbl[4] = '{"key9",      10'h1FF, 1'b1, 4'd9};
        tbl[5] = '{"key3",      10'h3F7, 1'b1, 4'd3};
        tbl[6] = '{"even_keys", 10'h2AA, 1'b1, 4'd8};
        tbl[7] = '{"all_keys",  10'h000, 1'b1, 4'd9};
        tbl[8] = '{"key6",      10'h3BF, 1'b1, 4'd6};

        m_reset();
        #2;
        do_reset();

        // Table: hold each pattern with no consumer, then inspect the held event.
        for (int r = 0; r < 9; r++) begin
            do_reset();
            for (int k = 0; k < 12; k++) step(tbl[r].s_n, 1'b0, 1'b0);
            check({"tbl_valid_", tbl[r].name}, key_valid, tbl[r].exp_valid);
            check({"tbl_code_", tbl[r].name}, key_code, tbl[r].exp_code);
            check({"tbl_ovf_", tbl[r].name}, ovf, 1'b0);
            for (int k = 0; k < 8; k++) step(10'h3FF, 1'b1, 1'b0);
        end

        // Key 5 held 30 cycles with a ready consumer: latency, pulse count, release time.
        do_reset();
        n_ev  = 0;
        exp_n = 1;
`ifdef KEY_REPEAT_EN
        for (int t = DEB_CYC + 4 + REPEAT_DLY; t <= 30; t += REPEAT_PER) exp_n++;
`endif
        for (int k = 1; k <= 30; k++) begin
            step(10'h3DF, 1'b1, 1'b0);
            if (k == DEB_CYC + 3) check("t1_valid_before_latency", key_valid, 1'b0);
            if (k == DEB_CYC + 4) begin
                check("t1_valid_at_latency", key_valid, 1'b1);
                check("t1_code", key_code, 4'd5);
            end
            if (key_valid) n_ev++;
        end
        check("t1_event_count", n_ev, exp_n);
        check("t1_held", key_held, 1'b1);
        rel_n = 0;
        for (int k = 1; k <= 10; k++) begin
            step(10'h3FF, 1'b1, 1'b0);
            if (!key_held && rel_n == 0) rel_n = k;
        end
        check("t1_release_within_7", (rel_n >= 1 && rel_n <= 7), 1'b1);

        // Key 3 bouncing, then stable.
        do_reset();
        n_ev = 0;
        for (int b = 0; b < 5; b++) begin
            step(10'h3F7, 1'b1, 1'b0);
            step(10'h3F7, 1'b1, 1'b0);
            step(10'h3FF, 1'b1, 1'b0);
            if (key_valid || key_held) n_ev++;
        end
        check("t2_no_event_in_bounce", n_ev, 0);
        seen_code = 4'hF;
        for (int k = 0; k < 15; k++) begin
            step(10'h3F7, 1'b1, 1'b0);
            if (key_valid) begin
                n_ev++;
                seen_code = key_code;
            end
        end
        check("t2_single_event", n_ev, 1);
        check("t2_code", seen_code, 4'd3);
        for (int k = 0; k < 8; k++) step(10'h3FF, 1'b1, 1'b0);

        // Backpressure: second press dropped, sticky flag, then drain and clear.
        do_reset();
        for (int k = 0; k < 12; k++) step(10'h3FD, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)  step(10'h3FF, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step(10'h3EF, 1'b0, 1'b0);
        check("t4_valid_kept", key_valid, 1'b1);
        check("t4_code_kept", key_code, 4'd1);
        check("t4_ovf_set", ovf, 1'b1);
        step(10'h3FF, 1'b1, 1'b0);
        check("t4_valid_drained", key_valid, 1'b0);
        check("t4_ovf_sticky", ovf, 1'b1);
        step(10'h3FF, 1'b0, 1'b1);
        check("t4_ovf_cleared", ovf, 1'b0);
        for (int k = 0; k < 8; k++) step(10'h3FF, 1'b1, 1'b0);

        // Reset while key 6 is held with a pending event; the key stays down afterwards.
        do_reset();
        for (int k = 0; k < 12; k++) step(10'h3BF, 1'b0, 1'b0);
        check("t5_pre_valid", key_valid, 1'b1);
        check("t5_pre_held", key_held, 1'b1);
        do_reset();
        for (int k = 1; k <= DEB_CYC + 4; k++) begin
            step(10'h3BF, 1'b0, 1'b0);
            if (k == DEB_CYC + 3) check("t5_valid_before_latency", key_valid, 1'b0);
        end
        check("t5_valid_after_reset", key_valid, 1'b1);
        check("t5_code_after_reset", key_code, 4'd6);
        for (int k = 0; k < 8; k++) step(10'h3FF, 1'b1, 1'b0);

        // Key 9 held 60 cycles: event timing with and without auto-repeat.
        do_reset();
        ev_q.delete();
        for (int k = 1; k <= 60; k++) begin
            step(10'h1FF, 1'b1, 1'b0);
            if (key_valid) ev_q.push_back(k);
        end
`ifdef KEY_REPEAT_EN
        check("t6_event_count_min", (ev_q.size() >= 3), 1'b1);
        if (ev_q.size() >= 3) begin
            check("t6_first_event", ev_q[0], DEB_CYC + 4);
            check("t6_second_event", ev_q[1], DEB_CYC + 4 + REPEAT_DLY);
            check("t6_third_event", ev_q[2], DEB_CYC + 4 + REPEAT_DLY + REPEAT_PER);
        end
`else
        check("t6_event_count", ev_q.size(), 1);
        if (ev_q.size() >= 1) check("t6_first_event", ev_q[0], DEB_CYC + 4);
`endif
        for (int k = 0; k < 8; k++) step(10'h3FF, 1'b1, 1'b0);

        // Random key traffic against the model.
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            int sel, dur;
            sel = int'($urandom_range(0, 9));
            if (sel <= 2)      pat = 10'h3FF;
            else if (sel <= 7) pat = ~(10'd1 << $urandom_range(0, 9));
            else               pat = 10'($urandom);
            dur = int'($urandom_range(1, 14));
            for (int k = 0; k < dur; k++) begin
                step(pat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
